bmi_alu_seq: RTL and testbench
==============================

Name: bmi_alu_seq

Overview:
- Parametrised, handshaked successor to the 256-bit bit-manipulation ALU.
- Supports parity, rotate-right, rotate-left, popcount, count-leading-zeros (CLZ) and count-trailing-zeros (CTZ).
- Count-type ops are evaluated iteratively, one CHUNK_WIDTH slice per cycle, so DATA_WIDTH can scale without a wide combinational tree.
- Sits between the operand register stage and the writeback stage; uses valid/ready on both sides.

Parameters:
- DATA_WIDTH, 256, operand/result width; power of 2, >= 8.
- CHUNK_WIDTH, 32, bits scanned per cycle for count ops; power of 2; must divide DATA_WIDTH.
- NCHUNK, DATA_WIDTH/CHUNK_WIDTH, derived (localparam), scan cycles per count op.
- SHW, log2(DATA_WIDTH), derived (localparam), rotate amount width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- opcode  input  3  000 PARITY, 001 ROTR, 010 ROTL, 011 POPCOUNT, 100 CLZ, 101 CTZ, 11x illegal
- A_in  input  DATA_WIDTH  operand
- B_in  input  DATA_WIDTH  rotate amount; only B_in[SHW-1:0] used
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Alu_out  output  DATA_WIDTH  result
- err  output  1  illegal opcode flag, qualified by out_valid
- busy  output  1  high in SCAN or DONE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, Alu_out=0, err=0, busy=0.
  - Internal accumulator and chunk counter are cleared.
  - Reset asserted mid-operation aborts the operation; no result is ever presented.
- Acceptance: a request is accepted when in_valid && in_ready at a clock edge.
  - opcode, A_in and B_in are captured into internal registers at acceptance.
  - Later input changes have no effect on that operation.
- in_ready = (state==IDLE). There is no overlap: one operation in flight at a time.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> DONE on accept of ROTR, ROTL or an illegal opcode. Result is registered in the same edge, so latency is 1 cycle.
  - IDLE -> SCAN on accept of PARITY, POPCOUNT, CLZ or CTZ. Chunk counter is set to 0 and the accumulator is cleared.
  - SCAN: processes one chunk per cycle; after chunk NCHUNK-1, goes to DONE. Latency is NCHUNK+1 cycles from the accept edge to the first out_valid=1 edge.
  - DONE: out_valid=1 and Alu_out/err are held stable until out_ready=1, then the state returns to IDLE.
  - in_ready stays 0 during the DONE cycle in which out_ready is sampled; the next request can be accepted one cycle later.
- Latency is fixed per op class; there is no early termination, so CLZ/CTZ timing is data-independent.
- ROTR: Alu_out = A rotated right by B_in[SHW-1:0]. An amount of 0 returns A unchanged. Amounts >= DATA_WIDTH wrap modulo DATA_WIDTH by truncation.
- ROTL: same as ROTR, rotating left.
- PARITY: Alu_out[0] = XOR of all A bits (1 = odd number of ones); upper bits are 0. Accumulated as a running XOR over chunks.
- POPCOUNT: Alu_out = count of ones in A, zero-extended; maximum value DATA_WIDTH. Accumulated as a running sum over chunks.
- CLZ: chunks are scanned from MSB to LSB.
  - A "found" flag latches on the first nonzero chunk, with result = (chunk index * CHUNK_WIDTH) + leading zeros within that chunk.
  - A=0 gives DATA_WIDTH.
- CTZ: same as CLZ, scanning from LSB to MSB; A=0 gives DATA_WIDTH.
- Illegal opcode: Alu_out=0, err=1, latency 1.
- err is 0 for all legal ops.
- Accumulator width is SHW+1 bits, which is sufficient for the value DATA_WIDTH; the result is zero-extended to DATA_WIDTH.
- busy = (state != IDLE).

Test Plan (DATA_WIDTH=256, CHUNK_WIDTH=32, NCHUNK=8):
- POPCOUNT, A=all ones, out_ready=1 -> out_valid rises 9 cycles after accept, Alu_out=256, err=0; A=0x0F0F -> Alu_out=8.
- ROTR A=1, B=1 -> Alu_out bit 255 set only, 1-cycle latency. ROTR A=1, B=257 -> same result. ROTL A=1<<255, B=1 -> Alu_out=1. B=0 -> Alu_out=A.
- CLZ/CTZ: CLZ A=0 -> 256; CLZ A=1<<40 -> 215; CTZ A=1<<40 -> 40; CTZ A=1<<255 -> 255; CLZ A=1<<255 -> 0. Each completes at 9-cycle latency.
- PARITY A=7 -> Alu_out=1; A=3 -> Alu_out=0. Opcode 110 -> err=1, Alu_out=0, 1-cycle latency.
- Backpressure: POPCOUNT completes with out_ready=0 for 5 cycles -> out_valid held, Alu_out stable, in_ready=0. Toggling A_in/in_valid during this window has no effect. After out_ready=1, in_ready=1 on the next cycle.
- Reset: assert rst_n=0 at SCAN cycle 4 -> out_valid=0, Alu_out=0, busy=0, in_ready=1 immediately (asynchronously). After release, a new ROTL A=1, B=4 returns 16.

Source files
------------

// File: rtl/bmi_alu_seq_if.sv
// Request/response bundle for bmi_alu_seq: valid/ready request side, valid/ready result side
// plus status flags. The master drives requests; the slave (the ALU) produces results.
interface bmi_alu_seq_if #(
  parameter int DATA_WIDTH = 256
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            opcode;
  logic [DATA_WIDTH-1:0] A_in;
  logic [DATA_WIDTH-1:0] B_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Alu_out;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, opcode, A_in, B_in, out_ready,
    input  in_ready, out_valid, Alu_out, err, busy
  );

  modport slave (
    input  in_valid, opcode, A_in, B_in, out_ready,
    output in_ready, out_valid, Alu_out, err, busy
  );
endinterface

// File: rtl/bmi_alu_seq.sv
// Handshaked bit-manipulation ALU: rotates finish in one cycle, count ops (parity, popcount,
// CLZ, CTZ) scan one CHUNK_WIDTH slice per cycle so wide operands avoid a deep reduction tree.
module bmi_alu_seq #(
  parameter int DATA_WIDTH  = 256,
  parameter int CHUNK_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  bmi_alu_seq_if.slave  bus
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int SHW    = $clog2(DATA_WIDTH);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_PARITY = 3'b000;
  localparam logic [2:0] OP_ROTR   = 3'b001;
  localparam logic [2:0] OP_ROTL   = 3'b010;
  localparam logic [2:0] OP_POPCNT = 3'b011;
  localparam logic [2:0] OP_CLZ    = 3'b100;
  localparam logic [2:0] OP_CTZ    = 3'b101;

  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [SHW:0]  ONE        = (SHW+1)'(1);
  localparam logic [SHW:0]  FULL_COUNT = (SHW+1)'(DATA_WIDTH);
  localparam logic [SHW:0]  CHUNK_SZ   = (SHW+1)'(CHUNK_WIDTH);

  logic [1:0]            state;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [CW-1:0]         cnt;
  logic [SHW:0]          acc;
  logic                  found;
  logic [DATA_WIDTH-1:0] alu_q;
  logic                  err_q;

  logic [CW-1:0]          chunk_idx;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic [SHW:0]           scan_base;
  logic [SHW:0]           acc_next;
  logic                   found_next;
  logic [SHW:0]           scan_result;
  logic [DATA_WIDTH-1:0]  ror_res;
  logic [DATA_WIDTH-1:0]  rol_res;

  function automatic logic [SHW:0] f_popcount(input logic [CHUNK_WIDTH-1:0] c);
    logic [SHW:0] n;
    n = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) n = n + (SHW+1)'(c[i]);
    return n;
  endfunction

  function automatic logic [SHW:0] f_lead_zeros(input logic [CHUNK_WIDTH-1:0] c);
    logic [SHW:0] n;
    logic         stop;
    n    = '0;
    stop = 1'b0;
    for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
      if (!stop) begin
        if (c[i]) stop = 1'b1;
        else      n = n + ONE;
      end
    end
    return n;
  endfunction

  function automatic logic [SHW:0] f_trail_zeros(input logic [CHUNK_WIDTH-1:0] c);
    logic [SHW:0] n;
    logic         stop;
    n    = '0;
    stop = 1'b0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (!stop) begin
        if (c[i]) stop = 1'b1;
        else      n = n + ONE;
      end
    end
    return n;
  endfunction

  // Rotates via a doubled operand; truncating the amount to SHW bits gives the modulo wrap.
  function automatic logic [DATA_WIDTH-1:0] f_rotr(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [SHW-1:0] sh);
    logic [2*DATA_WIDTH-1:0] d;
    d = {a, a} >> sh;
    return d[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_rotl(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [SHW-1:0] sh);
    logic [2*DATA_WIDTH-1:0] d;
    d = {a, a} << sh;
    return d[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  assign ror_res = f_rotr(bus.A_in, bus.B_in[SHW-1:0]);
  assign rol_res = f_rotl(bus.A_in, bus.B_in[SHW-1:0]);

  // CLZ walks chunks from the top down; every other count op walks upward from chunk 0.
  always_comb begin
    chunk_idx   = (op_q == OP_CLZ) ? (LAST_CHUNK - cnt) : cnt;
    chunk       = a_q[int'(chunk_idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
    scan_base   = (SHW+1)'(cnt) * CHUNK_SZ;
    found_next  = found | (chunk != '0);
    acc_next    = acc;
    case (op_q)
      OP_PARITY: acc_next = {{SHW{1'b0}}, acc[0] ^ (^chunk)};
      OP_POPCNT: acc_next = acc + f_popcount(chunk);
      OP_CLZ:    if (!found && chunk != '0) acc_next = scan_base + f_lead_zeros(chunk);
      OP_CTZ:    if (!found && chunk != '0) acc_next = scan_base + f_trail_zeros(chunk);
      default:   acc_next = acc;
    endcase
    scan_result = acc_next;
    if ((op_q == OP_CLZ || op_q == OP_CTZ) && !found_next) scan_result = FULL_COUNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= '0;
      a_q   <= '0;
      cnt   <= '0;
      acc   <= '0;
      found <= 1'b0;
      alu_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_q <= bus.opcode;
            a_q  <= bus.A_in;
            case (bus.opcode)
              OP_ROTR: begin
                alu_q <= ror_res;
                err_q <= 1'b0;
                state <= ST_DONE;
              end
              OP_ROTL: begin
                alu_q <= rol_res;
                err_q <= 1'b0;
                state <= ST_DONE;
              end
              OP_PARITY, OP_POPCNT, OP_CLZ, OP_CTZ: begin
                cnt   <= '0;
                acc   <= '0;
                found <= 1'b0;
                err_q <= 1'b0;
                state <= ST_SCAN;
              end
              default: begin
                alu_q <= '0;
                err_q <= 1'b1;
                state <= ST_DONE;
              end
            endcase
          end
        end
        ST_SCAN: begin
          acc   <= acc_next;
          found <= found_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_CHUNK) begin
            alu_q <= DATA_WIDTH'(scan_result);
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.Alu_out   = alu_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bmi_alu_seq.sv
// Directed bench for bmi_alu_seq at 256/32: every op class, latency, backpressure and
// asynchronous reset abort, each checked against hand-computed constants.
module tb_bmi_alu_seq;

  localparam int DW = 256;

  logic clk;
  logic rst_n;
  int   test_count;
  int   fail_count;
  int   lat;

  bmi_alu_seq_if #(.DATA_WIDTH(DW)) bus ();

  bmi_alu_seq #(.DATA_WIDTH(DW), .CHUNK_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one request and waits (bounded) until the result is presented; lat counts the
  // cycle after the accept edge as 1.
  task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, output int latency);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A_in     = a;
    bus.B_in     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A_in     = {8{$urandom()}};
    bus.B_in     = {8{$urandom()}};
    latency = 1;
    while (!bus.out_valid && latency < 40) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_alu,
                        input logic exp_err, input int exp_lat);
    int l;
    applyStimulus(op, a, b, l);
    checkOutput({tag, "_valid"}, DW'(bus.out_valid), DW'(1));
    checkOutput({tag, "_alu"}, bus.Alu_out, exp_alu);
    checkOutput({tag, "_err"}, DW'(bus.err), DW'(exp_err));
    checkOutput({tag, "_lat"}, DW'(l), DW'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] one;
    logic [DW-1:0] top;
    ones = '1;
    one  = DW'(1);
    top  = one << 255;
    test_count    = 0;
    fail_count    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 3'b000;
    bus.A_in      = '0;
    bus.B_in      = '0;
    bus.out_ready = 1'b1;
    #12;
    checkOutput("rst_in_ready", DW'(bus.in_ready), DW'(1));
    checkOutput("rst_out_valid", DW'(bus.out_valid), DW'(0));
    checkOutput("rst_alu", bus.Alu_out, '0);
    checkOutput("rst_err", DW'(bus.err), DW'(0));
    checkOutput("rst_busy", DW'(bus.busy), DW'(0));
    rst_n = 1'b1;

    run_op("pop_ones", 3'b011, ones, '0, DW'(256), 1'b0, 9);
    run_op("pop_0f0f", 3'b011, DW'(16'h0F0F), '0, DW'(8), 1'b0, 9);
    run_op("rotr_1_1", 3'b001, one, DW'(1), top, 1'b0, 1);
    run_op("rotr_1_257", 3'b001, one, DW'(257), top, 1'b0, 1);
    run_op("rotl_top_1", 3'b010, top, DW'(1), one, 1'b0, 1);
    run_op("rotr_b0", 3'b001, DW'(32'h1234_5678), '0, DW'(32'h1234_5678), 1'b0, 1);
    run_op("rotl_b3", 3'b010, DW'(16'h8001), DW'(3), DW'(20'h4_0008), 1'b0, 1);
    run_op("clz_zero", 3'b100, '0, '0, DW'(256), 1'b0, 9);
    run_op("clz_b40", 3'b100, one << 40, '0, DW'(215), 1'b0, 9);
    run_op("ctz_b40", 3'b101, one << 40, '0, DW'(40), 1'b0, 9);
    run_op("ctz_top", 3'b101, top, '0, DW'(255), 1'b0, 9);
    run_op("clz_top", 3'b100, top, '0, DW'(0), 1'b0, 9);
    run_op("ctz_zero", 3'b101, '0, '0, DW'(256), 1'b0, 9);
    run_op("par_7", 3'b000, DW'(7), '0, DW'(1), 1'b0, 9);
    run_op("par_3", 3'b000, DW'(3), '0, DW'(0), 1'b0, 9);
    run_op("par_split", 3'b000, (one << 200) | (one << 3) | (one << 100), '0, DW'(1), 1'b0, 9);
    run_op("illegal", 3'b110, ones, ones, '0, 1'b1, 1);

    // Backpressure: result must hold while the consumer stalls and inputs churn.
    bus.out_ready = 1'b0;
    applyStimulus(3'b011, DW'(8'hFF), '0, lat);
    checkOutput("bp_lat", DW'(lat), DW'(9));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.A_in     = ones;
      bus.opcode   = 3'b001;
      checkOutput("bp_valid", DW'(bus.out_valid), DW'(1));
      checkOutput("bp_alu", bus.Alu_out, DW'(8));
      checkOutput("bp_in_ready", DW'(bus.in_ready), DW'(0));
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("bp_rel_in_ready", DW'(bus.in_ready), DW'(0));
    @(posedge clk);
    #1;
    checkOutput("bp_after_in_ready", DW'(bus.in_ready), DW'(1));
    checkOutput("bp_after_valid", DW'(bus.out_valid), DW'(0));

    // Asynchronous reset in the middle of a scan aborts it immediately.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = 3'b011;
    bus.A_in     = ones;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scan_busy", DW'(bus.busy), DW'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", DW'(bus.out_valid), DW'(0));
    checkOutput("arst_alu", bus.Alu_out, '0);
    checkOutput("arst_busy", DW'(bus.busy), DW'(0));
    checkOutput("arst_in_ready", DW'(bus.in_ready), DW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_rotl", 3'b010, one, DW'(4), DW'(16), 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
